// File: rtl/cyclic_lamp.sv
// Free-running traffic-lamp sequencer RED -> GREEN -> YELLOW with per-phase dwell counts.
// Define CYCLIC_LAMP_REDYEL_EN to insert a RED_YELLOW phase between RED and GREEN.
module cyclic_lamp #(
   parameter int RED_TICKS    = 1,
   parameter int GREEN_TICKS  = 1,
   parameter int YELLOW_TICKS = 1,
   parameter int REDYEL_TICKS = 1
) (
   input  logic       clock,
   input  logic       reset,
   output logic [2:0] light
);

   localparam int RED_T    = (RED_TICKS    < 1) ? 1 : RED_TICKS;
   localparam int GREEN_T  = (GREEN_TICKS  < 1) ? 1 : GREEN_TICKS;
   localparam int YELLOW_T = (YELLOW_TICKS < 1) ? 1 : YELLOW_TICKS;
   localparam int MAX_RGY  = (RED_T > GREEN_T)
                             ? ((RED_T > YELLOW_T) ? RED_T : YELLOW_T)
                             : ((GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T);
`ifdef CYCLIC_LAMP_REDYEL_EN
   localparam int REDYEL_T = (REDYEL_TICKS < 1) ? 1 : REDYEL_TICKS;
   localparam int MAX_T    = (MAX_RGY > REDYEL_T) ? MAX_RGY : REDYEL_T;
`else
   localparam int MAX_T    = MAX_RGY;
`endif
   localparam int CW = $clog2(MAX_T) + 1;

   localparam logic [CW-1:0] LIM_RED    = CW'(RED_T - 1);
   localparam logic [CW-1:0] LIM_GREEN  = CW'(GREEN_T - 1);
   localparam logic [CW-1:0] LIM_YELLOW = CW'(YELLOW_T - 1);
`ifdef CYCLIC_LAMP_REDYEL_EN
   localparam logic [CW-1:0] LIM_REDYEL = CW'(REDYEL_T - 1);
`else
   // REDYEL_TICKS has no effect in this build; referenced only at elaboration.
   if (REDYEL_TICKS < 0) begin : g_redyel_ignored
   end
`endif

   typedef enum logic [1:0] {
      ST_RED    = 2'b00,
      ST_GREEN  = 2'b01,
      ST_YELLOW = 2'b10
`ifdef CYCLIC_LAMP_REDYEL_EN
      , ST_REDYEL = 2'b11
`endif
   } state_t;

   state_t          state_q, state_d, succ_s;
   logic [CW-1:0]   cnt_q, cnt_d, limit_s;
   logic            legal_s;
   logic [2:0]      light_q;

   // Unknown encodings fall back to RED so the lamp never shows dark or all-on.
   function automatic logic [2:0] lamp_decode(input state_t s);
      logic [2:0] l;
      case (s)
         ST_RED:    l = 3'b100;
         ST_GREEN:  l = 3'b010;
         ST_YELLOW: l = 3'b001;
`ifdef CYCLIC_LAMP_REDYEL_EN
         ST_REDYEL: l = 3'b101;
`endif
         default:   l = 3'b100;
      endcase
      return l;
   endfunction

   // Successor and dwell limit of the current phase; illegal states force RED.
   always_comb begin
      succ_s  = ST_RED;
      limit_s = {CW{1'b0}};
      legal_s = 1'b1;
      case (state_q)
         ST_RED: begin
            limit_s = LIM_RED;
`ifdef CYCLIC_LAMP_REDYEL_EN
            succ_s  = ST_REDYEL;
`else
            succ_s  = ST_GREEN;
`endif
         end
`ifdef CYCLIC_LAMP_REDYEL_EN
         ST_REDYEL: begin
            limit_s = LIM_REDYEL;
            succ_s  = ST_GREEN;
         end
`endif
         ST_GREEN: begin
            limit_s = LIM_GREEN;
            succ_s  = ST_YELLOW;
         end
         ST_YELLOW: begin
            limit_s = LIM_YELLOW;
            succ_s  = ST_RED;
         end
         default: begin
            limit_s = {CW{1'b0}};
            succ_s  = ST_RED;
            legal_s = 1'b0;
         end
      endcase

      // >= rather than == so a corrupted counter still advances the phase.
      if (!legal_s || (cnt_q >= limit_s)) begin
         state_d = succ_s;
         cnt_d   = {CW{1'b0}};
      end else begin
         state_d = state_q;
         cnt_d   = cnt_q + CW'(1);
      end
   end

   // State, dwell counter and lamp register; light is decoded from the next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_RED;
         cnt_q   <= {CW{1'b0}};
         light_q <= 3'b100;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         light_q <= lamp_decode(state_d);
      end
   end

   assign light = light_q;

endmodule

// File: tb/tb_cyclic_lamp.sv
// Directed table-driven bench for cyclic_lamp: default, 3/2/1 and mid-phase-reset configurations.
module tb_cyclic_lamp;

   logic       clock = 1'b0;
   logic       rst_a;
   logic       rst_b;
   logic [2:0] light_def, light_321, light_mid;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   cyclic_lamp u_def (
      .clock(clock), .reset(rst_a), .light(light_def)
   );
   cyclic_lamp #(.RED_TICKS(3), .GREEN_TICKS(2), .YELLOW_TICKS(1)) u_321 (
      .clock(clock), .reset(rst_a), .light(light_321)
   );
   cyclic_lamp #(.RED_TICKS(2), .GREEN_TICKS(4), .YELLOW_TICKS(1)) u_mid (
      .clock(clock), .reset(rst_b), .light(light_mid)
   );

   typedef struct {
      logic       rst;
      logic [2:0] exp_def;
      logic [2:0] exp_321;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: light=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit lamp_legal(input logic [2:0] l);
`ifdef CYCLIC_LAMP_REDYEL_EN
      return ($countones(l) == 1) || (l == 3'b101);
`else
      return $countones(l) == 1;
`endif
   endfunction

   initial begin
      int bad_def, bad_321, bad_mid;
      rst_a = 1'b1;
      rst_b = 1'b1;

      vecs[0]  = '{1'b1, 3'b100, 3'b100};
      vecs[1]  = '{1'b1, 3'b100, 3'b100};
      vecs[2]  = '{1'b1, 3'b100, 3'b100};
`ifdef CYCLIC_LAMP_REDYEL_EN
      vecs[3]  = '{1'b0, 3'b101, 3'b100};
      vecs[4]  = '{1'b0, 3'b010, 3'b100};
      vecs[5]  = '{1'b0, 3'b001, 3'b101};
      vecs[6]  = '{1'b0, 3'b100, 3'b010};
      vecs[7]  = '{1'b0, 3'b101, 3'b010};
      vecs[8]  = '{1'b0, 3'b010, 3'b001};
      vecs[9]  = '{1'b0, 3'b001, 3'b100};
      vecs[10] = '{1'b0, 3'b100, 3'b100};
      vecs[11] = '{1'b0, 3'b101, 3'b100};
      vecs[12] = '{1'b0, 3'b010, 3'b101};
      vecs[13] = '{1'b0, 3'b001, 3'b010};
      vecs[14] = '{1'b0, 3'b100, 3'b010};
`else
      vecs[3]  = '{1'b0, 3'b010, 3'b100};
      vecs[4]  = '{1'b0, 3'b001, 3'b100};
      vecs[5]  = '{1'b0, 3'b100, 3'b010};
      vecs[6]  = '{1'b0, 3'b010, 3'b010};
      vecs[7]  = '{1'b0, 3'b001, 3'b001};
      vecs[8]  = '{1'b0, 3'b100, 3'b100};
      vecs[9]  = '{1'b0, 3'b010, 3'b100};
      vecs[10] = '{1'b0, 3'b001, 3'b100};
      vecs[11] = '{1'b0, 3'b100, 3'b010};
      vecs[12] = '{1'b0, 3'b010, 3'b010};
      vecs[13] = '{1'b0, 3'b001, 3'b001};
      vecs[14] = '{1'b0, 3'b100, 3'b100};
`endif

      // Reset applied between edges, before any clock edge has occurred.
      #1;
      check("reset_no_edge_def", light_def, 3'b100);
      check("reset_no_edge_321", light_321, 3'b100);
      check("reset_no_edge_mid", light_mid, 3'b100);

      for (int i = 0; i < 15; i++) begin
         rst_a = vecs[i].rst;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_def", i), light_def, vecs[i].exp_def);
         check($sformatf("vec%0d_321", i), light_321, vecs[i].exp_321);
         @(negedge clock);
      end

      // Mid-phase reset: RED=2, GREEN=4, abort after two GREEN cycles.
      rst_b = 1'b0;
      @(posedge clock); #1;
      check("mid_red1", light_mid, 3'b100);
`ifdef CYCLIC_LAMP_REDYEL_EN
      @(posedge clock); #1;
      check("mid_redyel", light_mid, 3'b101);
`endif
      @(posedge clock); #1;
      check("mid_green1", light_mid, 3'b010);
      @(posedge clock); #1;
      check("mid_green2", light_mid, 3'b010);
      @(negedge clock);
      rst_b = 1'b1;
      #1;
      check("mid_abort_now", light_mid, 3'b100);
      @(posedge clock); #1;
      check("mid_abort_hold", light_mid, 3'b100);
      @(negedge clock);
      rst_b = 1'b0;
      @(posedge clock); #1;
      check("mid_rel_red", light_mid, 3'b100);
      @(posedge clock); #1;
`ifdef CYCLIC_LAMP_REDYEL_EN
      check("mid_rel_next", light_mid, 3'b101);
`else
      check("mid_rel_next", light_mid, 3'b010);
`endif

      // Legality of the lamp bus over 1000 cycles on every instance.
      bad_def = 0;
      bad_321 = 0;
      bad_mid = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clock);
         if (!lamp_legal(light_def)) bad_def++;
         if (!lamp_legal(light_321)) bad_321++;
         if (!lamp_legal(light_mid)) bad_mid++;
      end
      n_vec++;
      if (bad_def != 0) begin
         n_bad++;
         $display("FAIL invariant_def: illegal cycles=%0d expected 0", bad_def);
      end
      n_vec++;
      if (bad_321 != 0) begin
         n_bad++;
         $display("FAIL invariant_321: illegal cycles=%0d expected 0", bad_321);
      end
      n_vec++;
      if (bad_mid != 0) begin
         n_bad++;
         $display("FAIL invariant_mid: illegal cycles=%0d expected 0", bad_mid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
